matrix_display_formatter: RTL and testbench
===========================================

Name: matrix_display_formatter

Overview:
- Downstream consumer of the matrix store's read/display port.
- On a display request it:
  - Issues start_disp to the store.
  - Pulls elements one at a time with read_en.
  - Converts each signed 8-bit element to ASCII decimal.
  - Streams a header line, then rows of text, to the UART transmitter over a valid/ready byte handshake.
- Reports done or error to the top-level controller.

Parameters:
- TIMEOUT_CYCLES, 16: cycles to wait for meta_info_valid/error_flag or matrix_data_valid before aborting.
- SEP_CHAR, 8'h20: byte emitted between elements within a row.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  display request pulse, accepted only in IDLE
- disp_id  in  4  matrix slot to display (0..9)
- disp_m  in  3  row count of that slot (from list_m)
- disp_n  in  3  column count of that slot (from list_n)
- busy  out  1  high from accepted start until return to IDLE
- done  out  1  one-cycle pulse after last CRLF transferred
- err  out  1  one-cycle pulse on invalid request, store error, or timeout
- start_disp  out  1  one-cycle pulse to store
- matrix_id_in  out  4  slot id driven to store, stable while busy
- read_en  out  1  one-cycle pulse per element fetch
- meta_info_valid  in  1  store accepted display request
- error_flag  in  1  store rejected request
- data_in  in  8  element from store (data_out)
- data_valid  in  1  store matrix_data_valid, aligned with data_in
- tx_data  out  8  ASCII byte to UART TX
- tx_valid  out  1  byte valid
- tx_ready  in  1  UART TX can accept

Behaviour:
- Reset: every output is 0 and the FSM goes to IDLE. Reset mid-operation aborts within the same edge; no done or err pulse is issued.
- Transfer rule: a byte transfers on a clk edge with tx_valid && tx_ready. tx_data stays stable while tx_valid && !tx_ready. tx_valid never drops without a transfer, except on reset.
- IDLE, start=1:
  - Latch id, m and n.
  - If id>9, m∉1..5 or n∉1..5: err pulse next cycle, stay IDLE, no start_disp.
  - Otherwise: busy=1, go to REQ.
- REQ: pulse start_disp for 1 cycle, then go to WAIT_META.
- WAIT_META:
  - meta_info_valid: go to HDR.
  - error_flag, or TIMEOUT_CYCLES elapsed: err pulse, go to IDLE.
  - If both inputs are high in the same cycle, error_flag wins.
- HDR: emit the 7 bytes '0'+id, ':', '0'+m, 'x', '0'+n, 8'h0D, 8'h0A. Then row=0, col=0, go to FETCH.
- FETCH: pulse read_en for exactly 1 cycle, then go to WAIT_DATA.
- WAIT_DATA:
  - On data_valid: capture data_in, go to CONV.
  - If TIMEOUT_CYCLES elapse first: err pulse, go to IDLE.
  - A data_valid seen in any other state is ignored.
- CONV (1 cycle):
  - Treat the element as signed 8-bit; mag = |v| in 9 bits, so -128 gives 128.
  - h = mag/100, t = (mag/10)%10, o = mag%10.
  - Build a char list: '-' if v<0; h if h≠0; t if h≠0 or t≠0; then always o. Length is 1..4.
- EMIT: send the built chars in order.
- SEP:
  - col<n-1: send SEP_CHAR, col++, go to FETCH.
  - col=n-1, row<m-1: send 0D, 0A; col=0, row++; go to FETCH.
  - col=n-1, row=m-1: send 0D, 0A, pulse done, busy=0, go to IDLE.
- Element count is exactly m*n read_en pulses. There is no read-ahead: the next read_en is only issued after the previous element's last byte has been accepted.
- start while busy: ignored.
- tx_ready held low indefinitely: the FSM stalls with no timeout. Timeouts apply only to store responses.

Optional Feature:
- Macro DISP_PAD_EN.
- Defined: each element is right-aligned to 4 characters by emitting (4 - length) leading 8'h20 bytes before the sign/digits in EMIT, so columns line up. SEP_CHAR still separates elements.
- Undefined: no padding; output is exactly as described in Behaviour.

Test Plan:
- Slot 3, 2x2, elements {5, -12, 100, -128}, tx_ready=1 → bytes "3:2x2\r\n5 -12\r\n100 -128\r\n"; done pulse; exactly 4 read_en pulses.
- Same request with tx_ready toggling 1/0 every cycle → identical byte stream; tx_data stable across all stalled cycles.
- start with disp_id=11 → err pulse 1 cycle later; no start_disp; busy stays 0.
- Store answers start_disp with error_flag → err pulse; no tx_valid; back in IDLE.
- Store withholds data_valid after the 2nd read_en → err exactly TIMEOUT_CYCLES=16 cycles later; new start accepted afterwards.
- rst asserted mid-EMIT → next cycle tx_valid=0, busy=0, no done/err. With DISP_PAD_EN, element 7 → "   7".

Source files
------------

// File: rtl/matrix_display_formatter.sv
`default_nettype none
// ============================================================================
// Module   : matrix_display_formatter
// Brief    : Pulls a matrix from the store element by element and streams it
//            as ASCII decimal text (header + rows) over a valid/ready byte port.
//            Optional macro DISP_PAD_EN right-aligns each element to 4 chars.
// Revision : 1.0 - initial release
// ============================================================================
module matrix_display_formatter #(
    parameter int          TIMEOUT_CYCLES = 16,
    parameter logic [7:0]  SEP_CHAR       = 8'h20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] disp_id,
    input  logic [2:0] disp_m,
    input  logic [2:0] disp_n,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       start_disp,
    output logic [3:0] matrix_id_in,
    output logic       read_en,
    input  logic       meta_info_valid,
    input  logic       error_flag,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready
);

    localparam int c_TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_REQ       = 4'd1,
        S_WAIT_META = 4'd2,
        S_HDR       = 4'd3,
        S_FETCH     = 4'd4,
        S_WAIT_DATA = 4'd5,
        S_CONV      = 4'd6,
        S_EMIT      = 4'd7,
        S_SEP       = 4'd8
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [3:0]         r_id;
    logic [2:0]         r_m;
    logic [2:0]         r_n;
    logic [2:0]         r_row;
    logic [2:0]         r_col;
    logic [c_TMO_W-1:0] r_tmo;
    logic [7:0]         r_elem;
    logic [7:0]         r_buf [8];
    logic [2:0]         r_idx;
    logic [2:0]         r_last;
    logic               r_done;
    logic               r_err;

    logic               w_req_ok;
    logic               w_tmo_hit;
    logic               w_xfer;
    logic               w_last_byte;
    logic               w_col_end;
    logic               w_row_end;

    // ASCII conversion of the captured element
    logic               w_neg;
    logic [8:0]         w_mag;
    logic               w_hund;
    logic [6:0]         w_rem;
    logic [3:0]         w_tens;
    logic [3:0]         w_ones;
    logic [2:0]         w_len;
    logic [2:0]         w_last_idx;
    logic [1:0]         w_pos;
    logic [7:0]         w_cv [4];

    assign w_req_ok  = (disp_id <= 4'd9) &&
                       (disp_m != 3'd0) && (disp_m <= 3'd5) &&
                       (disp_n != 3'd0) && (disp_n <= 3'd5);
    assign w_tmo_hit = (r_tmo == c_TMO_W'(TIMEOUT_CYCLES - 1));
    assign w_xfer      = tx_valid && tx_ready;
    assign w_last_byte = w_xfer && (r_idx == r_last);
    assign w_col_end   = (r_col == r_n - 3'd1);
    assign w_row_end   = (r_row == r_m - 3'd1);

    assign w_neg  = r_elem[7];
    assign w_mag  = w_neg ? (9'd256 - {1'b0, r_elem}) : {1'b0, r_elem};
    assign w_hund = (w_mag >= 9'd100);
    assign w_rem  = w_hund ? 7'(w_mag - 9'd100) : 7'(w_mag);
    assign w_tens = 4'(w_rem / 7'd10);
    assign w_ones = 4'(w_rem % 7'd10);
    assign w_len  = 3'd1 + {2'b00, w_neg} + {2'b00, w_hund} +
                    {2'b00, (w_hund || (w_tens != 4'd0))};

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_cv[i] = 8'h20;
        end
`ifdef DISP_PAD_EN
        w_pos      = 2'(3'd4 - w_len);
        w_last_idx = 3'd3;
`else
        w_pos      = 2'd0;
        w_last_idx = w_len - 3'd1;
`endif
        if (w_neg) begin
            w_cv[w_pos] = 8'h2D;
            w_pos       = w_pos + 2'd1;
        end
        if (w_hund) begin
            w_cv[w_pos] = 8'h31;
            w_pos       = w_pos + 2'd1;
        end
        if (w_hund || (w_tens != 4'd0)) begin
            w_cv[w_pos] = 8'h30 + {4'b0000, w_tens};
            w_pos       = w_pos + 2'd1;
        end
        w_cv[w_pos] = 8'h30 + {4'b0000, w_ones};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        busy         = (r_state != S_IDLE);
        start_disp   = 1'b0;
        read_en      = 1'b0;
        tx_valid     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start && w_req_ok) w_state_next = S_REQ;
            end
            S_REQ: begin
                start_disp   = 1'b1;
                w_state_next = S_WAIT_META;
            end
            S_WAIT_META: begin
                if (error_flag)           w_state_next = S_IDLE;
                else if (meta_info_valid) w_state_next = S_HDR;
                else if (w_tmo_hit)       w_state_next = S_IDLE;
            end
            S_HDR: begin
                tx_valid = 1'b1;
                if (w_last_byte) w_state_next = S_FETCH;
            end
            S_FETCH: begin
                read_en      = 1'b1;
                w_state_next = S_WAIT_DATA;
            end
            S_WAIT_DATA: begin
                if (data_valid)     w_state_next = S_CONV;
                else if (w_tmo_hit) w_state_next = S_IDLE;
            end
            S_CONV: begin
                w_state_next = S_EMIT;
            end
            S_EMIT: begin
                tx_valid = 1'b1;
                if (w_last_byte) w_state_next = S_SEP;
            end
            S_SEP: begin
                tx_valid = 1'b1;
                if (w_last_byte) begin
                    w_state_next = (w_col_end && w_row_end) ? S_IDLE : S_FETCH;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign tx_data      = tx_valid ? r_buf[r_idx] : 8'h00;
    assign matrix_id_in = r_id;
    assign done         = r_done;
    assign err          = r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_id   <= 4'd0;
            r_m    <= 3'd0;
            r_n    <= 3'd0;
            r_row  <= 3'd0;
            r_col  <= 3'd0;
            r_tmo  <= '0;
            r_elem <= 8'h00;
            r_idx  <= 3'd0;
            r_last <= 3'd0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                r_buf[i] <= 8'h00;
            end
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            // Byte pointer advances on every accepted byte except the last
            if (w_xfer && !w_last_byte) r_idx <= r_idx + 3'd1;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_id <= disp_id;
                        r_m  <= disp_m;
                        r_n  <= disp_n;
                        if (!w_req_ok) r_err <= 1'b1;
                    end
                end
                S_REQ: r_tmo <= c_TMO_W'(1);
                S_WAIT_META: begin
                    if (error_flag) begin
                        r_err <= 1'b1;
                    end else if (meta_info_valid) begin
                        r_buf[0] <= 8'h30 + {4'b0000, r_id};
                        r_buf[1] <= 8'h3A;
                        r_buf[2] <= 8'h30 + {5'b00000, r_m};
                        r_buf[3] <= 8'h78;
                        r_buf[4] <= 8'h30 + {5'b00000, r_n};
                        r_buf[5] <= 8'h0D;
                        r_buf[6] <= 8'h0A;
                        r_idx    <= 3'd0;
                        r_last   <= 3'd6;
                    end else if (w_tmo_hit) begin
                        r_err <= 1'b1;
                    end else begin
                        r_tmo <= r_tmo + c_TMO_W'(1);
                    end
                end
                S_HDR: begin
                    if (w_last_byte) begin
                        r_row <= 3'd0;
                        r_col <= 3'd0;
                    end
                end
                S_FETCH: r_tmo <= c_TMO_W'(1);
                S_WAIT_DATA: begin
                    if (data_valid)     r_elem <= data_in;
                    else if (w_tmo_hit) r_err  <= 1'b1;
                    else                r_tmo  <= r_tmo + c_TMO_W'(1);
                end
                S_CONV: begin
                    for (int i = 0; i < 4; i++) begin
                        r_buf[i] <= w_cv[i];
                    end
                    r_idx  <= 3'd0;
                    r_last <= w_last_idx;
                end
                S_EMIT: begin
                    if (w_last_byte) begin
                        r_idx <= 3'd0;
                        if (w_col_end) begin
                            r_buf[0] <= 8'h0D;
                            r_buf[1] <= 8'h0A;
                            r_last   <= 3'd1;
                        end else begin
                            r_buf[0] <= SEP_CHAR;
                            r_last   <= 3'd0;
                        end
                    end
                end
                S_SEP: begin
                    if (w_last_byte) begin
                        if (!w_col_end) begin
                            r_col <= r_col + 3'd1;
                        end else if (!w_row_end) begin
                            r_col <= 3'd0;
                            r_row <= r_row + 3'd1;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_matrix_display_formatter.sv
`default_nettype none
// ============================================================================
// Module   : tb_matrix_display_formatter
// Brief    : Directed self-checking bench with a small store / UART model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_matrix_display_formatter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] disp_id = 4'd0;
    logic [2:0] disp_m = 3'd0;
    logic [2:0] disp_n = 3'd0;
    logic       busy, done, err, start_disp, read_en, tx_valid;
    logic [3:0] matrix_id_in;
    logic [7:0] tx_data;
    logic       meta_info_valid = 1'b0;
    logic       error_flag = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       data_valid = 1'b0;
    logic       tx_ready = 1'b0;

    matrix_display_formatter #(.TIMEOUT_CYCLES(16), .SEP_CHAR(8'h20)) u_dut (
        .clk(clk), .rst(rst), .start(start), .disp_id(disp_id),
        .disp_m(disp_m), .disp_n(disp_n), .busy(busy), .done(done), .err(err),
        .start_disp(start_disp), .matrix_id_in(matrix_id_in), .read_en(read_en),
        .meta_info_valid(meta_info_valid), .error_flag(error_flag),
        .data_in(data_in), .data_valid(data_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    int         store_mode  = 0;   // 0 meta, 1 error_flag, 2 silent
    int         withhold_at = 99;  // read index whose data is never returned
    int         ready_mode  = 1;   // 0 low, 1 high, 2 toggle
    logic [7:0] elems [4];

    logic [7:0] rx_q [$];
    int n_read, n_sd, n_done, n_err, n_txv, n_stall_bad;
    int last_read_cyc, err_cyc;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'h00;

`ifdef DISP_PAD_EN
    string e_main = "3:2x2\r\n   5  -12\r\n 100 -128\r\n";
    string e_one  = "9:1x1\r\n   0\r\n";
`else
    string e_main = "3:2x2\r\n5 -12\r\n100 -128\r\n";
    string e_one  = "9:1x1\r\n0\r\n";
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    always @(posedge clk) cyc++;

    // Store and UART-ready model, driven just after each active edge
    logic pend_meta = 1'b0, pend_data = 1'b0;
    int   st_reads = 0, data_idx = 0;
    always begin
        @(posedge clk);
        #1;
        meta_info_valid = 1'b0;
        error_flag      = 1'b0;
        data_valid      = 1'b0;
        if (ready_mode == 2) tx_ready = ~tx_ready;
        else                 tx_ready = (ready_mode == 1);
        if (rst) begin
            pend_meta = 1'b0;
            pend_data = 1'b0;
        end else begin
            if (pend_meta) begin
                if (store_mode == 1)      error_flag      = 1'b1;
                else if (store_mode == 0) meta_info_valid = 1'b1;
                pend_meta = 1'b0;
            end
            if (pend_data) begin
                data_in    = elems[data_idx % 4];
                data_valid = 1'b1;
                pend_data  = 1'b0;
            end
            if (start_disp) begin
                pend_meta = 1'b1;
                st_reads  = 0;
            end
            if (read_en) begin
                if (st_reads != withhold_at) begin
                    pend_data = 1'b1;
                    data_idx  = st_reads;
                end
                st_reads++;
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (tx_valid && tx_ready) rx_q.push_back(tx_data);
            if (prev_stall && (!tx_valid || tx_data != prev_data)) n_stall_bad++;
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
            if (read_en) begin
                n_read++;
                last_read_cyc = cyc;
            end
            if (start_disp) n_sd++;
            if (done) n_done++;
            if (err) begin
                n_err++;
                err_cyc = cyc;
            end
            if (tx_valid) n_txv++;
        end
    end

    task automatic tick(input int k = 1);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic clear_stats();
        rx_q.delete();
        n_read = 0; n_sd = 0; n_done = 0; n_err = 0; n_txv = 0; n_stall_bad = 0;
        last_read_cyc = 0; err_cyc = 0;
    endtask

    task automatic request(input logic [3:0] id, input logic [2:0] m, input logic [2:0] n);
        disp_id = id; disp_m = m; disp_n = n;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_end(input int budget);
        for (int i = 0; i < budget && (n_done + n_err) == 0; i++) tick();
        if ((n_done + n_err) == 0) check("wait_end", n_done + n_err, 1);
        tick(2);
    endtask

    task automatic check_str(input string tag, input string exp);
        logic [7:0] got;
        check({tag, "_len"}, rx_q.size(), exp.len());
        for (int i = 0; i < exp.len(); i++) begin
            got = (i < rx_q.size()) ? rx_q[i] : 8'h00;
            check(tag, got, exp[i]);
        end
    endtask

    initial begin
        elems = '{8'h05, 8'hF4, 8'h64, 8'h80};
        clear_stats();
        tick(3);
        check("rst_busy", busy, 0);
        check("rst_txv", tx_valid, 0);
        check("rst_done_err", {done, err, start_disp, read_en}, 0);
        check("rst_txdata", tx_data, 0);
        rst = 1'b0;
        tick(2);

        // Nominal 2x2 display
        clear_stats();
        request(4'd3, 3'd2, 3'd2);
        wait_end(400);
        check_str("main", e_main);
        check("main_reads", n_read, 4);
        check("main_done", n_done, 1);
        check("main_err", n_err, 0);
        check("main_sd", n_sd, 1);
        check("main_busy", busy, 0);

        // Back-pressure every other cycle
        ready_mode = 2;
        clear_stats();
        request(4'd3, 3'd2, 3'd2);
        wait_end(800);
        check_str("stall", e_main);
        check("stall_stable", n_stall_bad, 0);
        check("stall_reads", n_read, 4);
        check("stall_done", n_done, 1);
        ready_mode = 1;

        // Invalid requests: err one cycle later, store untouched
        clear_stats();
        request(4'd11, 3'd2, 3'd2);
        check("bad_id_err", err, 1);
        check("bad_id_busy", busy, 0);
        tick();
        check("bad_id_pulse", err, 0);
        request(4'd5, 3'd6, 3'd2);
        check("bad_m_err", err, 1);
        request(4'd5, 3'd2, 3'd0);
        check("bad_n_err", err, 1);
        tick(2);
        check("bad_no_sd", n_sd, 0);
        check("bad_err_cnt", n_err, 3);

        // Smallest matrix, largest id, zero element
        elems[0] = 8'h00;
        clear_stats();
        request(4'd9, 3'd1, 3'd1);
        wait_end(200);
        check_str("one", e_one);
        check("one_reads", n_read, 1);

        // Store rejects request
        elems = '{8'h05, 8'hF4, 8'h64, 8'h80};
        store_mode = 1;
        clear_stats();
        request(4'd3, 3'd2, 3'd2);
        wait_end(100);
        check("reject_err", n_err, 1);
        check("reject_txv", n_txv, 0);
        check("reject_busy", busy, 0);
        store_mode = 0;

        // Data withheld after second read
        withhold_at = 1;
        clear_stats();
        request(4'd3, 3'd2, 3'd2);
        wait_end(400);
        check("tmo_err", n_err, 1);
        check("tmo_delay", err_cyc - last_read_cyc, 16);
        check("tmo_reads", n_read, 2);
        check("tmo_done", n_done, 0);
        withhold_at = 99;
        clear_stats();
        request(4'd3, 3'd2, 3'd2);
        wait_end(400);
        check("after_tmo_done", n_done, 1);
        check_str("after_tmo", e_main);

        // Reset in the middle of emitting "-128"
        elems = '{8'h80, 8'hF4, 8'h64, 8'h05};
        clear_stats();
        request(4'd3, 3'd2, 3'd2);
        for (int i = 0; i < 100 && rx_q.size() < 8; i++) tick();
        check("mid_txv", tx_valid, 1);
        check("mid_id", matrix_id_in, 3);
        rst = 1'b1;
        tick();
        check("mid_rst_txv", tx_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_pulses", {done, err}, 0);
        tick();
        rst = 1'b0;
        tick(3);
        check("mid_no_done_err", n_done + n_err, 0);
        check_str("mid_bytes", "3:2x2\r\n-");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
